// File: rtl/player_pkg.sv
// Shared types and scan-code constants for the DE1 music player controller.
package player_pkg;

    typedef enum logic [2:0] {
        STOP     = 3'd0,
        FADE_IN  = 3'd1,
        PLAY     = 3'd2,
        FADE_OUT = 3'd3,
        SWITCH   = 3'd4,
        PAUSE    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_NEXT = 3'd1,
        CMD_PREV = 3'd2,
        CMD_VUP  = 3'd3,
        CMD_VDN  = 3'd4,
        CMD_STOP = 3'd5,
        CMD_PLAY = 3'd6
    } cmd_t;

    localparam logic [7:0] KEY_NEXT = 8'h05;
    localparam logic [7:0] KEY_PREV = 8'h06;
    localparam logic [7:0] KEY_VUP  = 8'h04;
    localparam logic [7:0] KEY_VDN  = 8'h0C;
    localparam logic [7:0] KEY_STOP = 8'h03;
    localparam logic [7:0] KEY_PLAY = 8'h0B;
    localparam logic [7:0] KEY_BRK  = 8'hF0;

    // Map a make-code byte to a transport/volume command.
    function automatic cmd_t decode_key(input logic [7:0] b);
        cmd_t c;
        case (b)
            KEY_NEXT: c = CMD_NEXT;
            KEY_PREV: c = CMD_PREV;
            KEY_VUP:  c = CMD_VUP;
            KEY_VDN:  c = CMD_VDN;
            KEY_STOP: c = CMD_STOP;
            KEY_PLAY: c = CMD_PLAY;
            default:  c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/player_ctl_gen_vol_ramp.sv
// vol_ramp: steps vol_out one level toward goal every RAMP_TICKS tick pulses.
// clr restarts the tick counter; zero forces vol_out to 0 at once.
module vol_ramp #(
    parameter int VOL_W      = 4,
    parameter int RAMP_TICKS = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic             zero,
    input  logic [VOL_W-1:0] goal,
    output logic [VOL_W-1:0] vol_out
);
    localparam int CNT_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAMP_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VOL_W-1:0] vol_q, vol_d;

    // Tick counter and one-step move toward goal on counter wrap.
    always_comb begin
        cnt_d = cnt_q;
        vol_d = vol_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (vol_q < goal)
                    vol_d = vol_q + VOL_W'(1);
                else if (vol_q > goal)
                    vol_d = vol_q - VOL_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (zero)
            vol_d = '0;
    end

    // Ramp state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            vol_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vol_q <= vol_d;
        end
    end

    assign vol_out = vol_q;

endmodule

// File: rtl/player_ctl_gen.sv
// player_ctl_gen: PS/2 command decode, transport FSM, song index and volume
// target for the DE1 music player. Optional macro PLAYER_AUTO_NEXT_EN makes
// song_end advance to the next track instead of stopping.
module player_ctl_gen
    import player_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int VOL_W      = 4,
    parameter int VOL_RESET  = 8,
    parameter int RAMP_TICKS = 48,
    parameter int WRAP       = 1,
    localparam int SONG_W    = $clog2(NUM_SONGS)
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic [7:0]        ps2_byte,
    input  logic              ps2_vld,
    input  logic              tick,
    input  logic              song_end,
    output logic [SONG_W-1:0] song_idx,
    output logic              playing,
    output logic [VOL_W-1:0]  vol_out,
    output logic [VOL_W-1:0]  vol_tgt,
    output logic [3:0]        hex_digit
);
    localparam logic [SONG_W-1:0] LAST    = SONG_W'(NUM_SONGS - 1);
    localparam logic [VOL_W-1:0]  VOL_MAX = {VOL_W{1'b1}};

    state_t            state_q, state_d;
    state_t            dest_q, dest_d;
    logic              dir_prev_q, dir_prev_d;
    logic              brk_q, brk_d;
    logic [SONG_W-1:0] idx_q, idx_d;
    logic [VOL_W-1:0]  vol_tgt_q, vol_tgt_d;
    cmd_t              cmd;
    logic [VOL_W-1:0]  ramp_goal;
    logic [31:0]       hex_full;

    // Neighbouring track index, wrapping or saturating at the ends.
    function automatic logic [SONG_W-1:0] step_idx(input logic [SONG_W-1:0] idx,
                                                   input logic prev);
        logic [SONG_W-1:0] r;
        if (!prev)
            r = (idx == LAST) ? ((WRAP != 0) ? '0 : LAST) : idx + SONG_W'(1);
        else
            r = (idx == '0) ? ((WRAP != 0) ? LAST : '0) : idx - SONG_W'(1);
        return r;
    endfunction

    // Saturating volume target adjust.
    function automatic logic [VOL_W-1:0] vol_adj(input logic [VOL_W-1:0] v,
                                                 input cmd_t c);
        logic [VOL_W-1:0] r;
        r = v;
        if (c == CMD_VUP && v != VOL_MAX)
            r = v + VOL_W'(1);
        else if (c == CMD_VDN && v != '0)
            r = v - VOL_W'(1);
        return r;
    endfunction

    // Break-code filter: the byte after F0 is swallowed.
    always_comb begin
        brk_d = brk_q;
        cmd   = CMD_NONE;
        if (ps2_vld) begin
            if (brk_q)
                brk_d = 1'b0;
            else if (ps2_byte == KEY_BRK)
                brk_d = 1'b1;
            else
                cmd = decode_key(ps2_byte);
        end
    end

    // Transport FSM, pending switch direction and song index.
    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        dir_prev_d = dir_prev_q;
        idx_d      = idx_q;
        vol_tgt_d  = vol_adj(vol_tgt_q, cmd);
        if (cmd == CMD_STOP) begin
            state_d = STOP;
        end else begin
            case (state_q)
                STOP, PAUSE: begin
                    if (cmd == CMD_PLAY)
                        state_d = FADE_IN;
                    else if (cmd == CMD_NEXT || cmd == CMD_PREV)
                        idx_d = step_idx(idx_q, cmd == CMD_PREV);
                end
                FADE_IN, PLAY: begin
                    if (cmd == CMD_PLAY) begin
                        state_d = FADE_OUT;
                        dest_d  = PAUSE;
                    end else if (cmd == CMD_NEXT || cmd == CMD_PREV) begin
                        state_d    = FADE_OUT;
                        dest_d     = SWITCH;
                        dir_prev_d = (cmd == CMD_PREV);
                    end else if (state_q == FADE_IN) begin
                        if (vol_out == vol_tgt_q)
                            state_d = PLAY;
                    end else if (song_end && cmd == CMD_NONE) begin
`ifdef PLAYER_AUTO_NEXT_EN
                        if (WRAP == 0 && idx_q == LAST) begin
                            state_d = STOP;
                        end else begin
                            state_d    = FADE_OUT;
                            dest_d     = SWITCH;
                            dir_prev_d = 1'b0;
                        end
`else
                        state_d = STOP;
`endif
                    end
                end
                FADE_OUT: begin
                    if (cmd == CMD_PLAY) begin
                        state_d = FADE_IN;
                    end else begin
                        // Later next/prev replaces the pending direction.
                        if ((cmd == CMD_NEXT || cmd == CMD_PREV) && dest_q == SWITCH)
                            dir_prev_d = (cmd == CMD_PREV);
                        if (vol_out == '0)
                            state_d = dest_q;
                    end
                end
                SWITCH: begin
                    idx_d   = step_idx(idx_q, dir_prev_q);
                    state_d = FADE_IN;
                end
                default: state_d = STOP;
            endcase
        end
    end

    // Control and index registers.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= STOP;
            dest_q     <= PAUSE;
            dir_prev_q <= 1'b0;
            brk_q      <= 1'b0;
            idx_q      <= '0;
            vol_tgt_q  <= VOL_W'(VOL_RESET);
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            dir_prev_q <= dir_prev_d;
            brk_q      <= brk_d;
            idx_q      <= idx_d;
            vol_tgt_q  <= vol_tgt_d;
        end
    end

    assign ramp_goal = (state_q == PLAY || state_q == FADE_IN) ? vol_tgt_q : '0;

    vol_ramp #(
        .VOL_W      (VOL_W),
        .RAMP_TICKS (RAMP_TICKS)
    ) u_ramp (
        .clk     (clk),
        .rst     (sys_rst),
        .tick    (tick),
        .clr     (state_d != state_q),
        .zero    (state_d == STOP),
        .goal    (ramp_goal),
        .vol_out (vol_out)
    );

    assign hex_full  = 32'(idx_q) + 32'd1;
    assign hex_digit = (hex_full > 32'd15) ? 4'hF : hex_full[3:0];
    assign song_idx  = idx_q;
    assign vol_tgt   = vol_tgt_q;
    assign playing   = (state_q == PLAY) || (state_q == FADE_IN) ||
                       (state_q == FADE_OUT) || (state_q == SWITCH);

endmodule

// File: tb/tb_player_ctl_gen.sv
// Directed bench for player_ctl_gen: a WRAP=1 and a WRAP=0 instance share inputs.
module tb_player_ctl_gen;
    import player_pkg::*;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic [7:0] ps2_byte;
    logic       ps2_vld, tick, song_end;
    logic [1:0] idx_a, idx_b;
    logic       ply_a, ply_b;
    logic [3:0] vol_a, vol_b, tgt_a, tgt_b, hex_a, hex_b;

    int n_chk  = 0;
    int n_fail = 0;

    player_ctl_gen #(.NUM_SONGS(4), .VOL_W(4), .VOL_RESET(8), .RAMP_TICKS(2), .WRAP(1)) dut_a (
        .clk(clk), .sys_rst(sys_rst), .ps2_byte(ps2_byte), .ps2_vld(ps2_vld),
        .tick(tick), .song_end(song_end), .song_idx(idx_a), .playing(ply_a),
        .vol_out(vol_a), .vol_tgt(tgt_a), .hex_digit(hex_a));

    player_ctl_gen #(.NUM_SONGS(4), .VOL_W(4), .VOL_RESET(8), .RAMP_TICKS(2), .WRAP(0)) dut_b (
        .clk(clk), .sys_rst(sys_rst), .ps2_byte(ps2_byte), .ps2_vld(ps2_vld),
        .tick(tick), .song_end(song_end), .song_idx(idx_b), .playing(ply_b),
        .vol_out(vol_b), .vol_tgt(tgt_b), .hex_digit(hex_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       vld;
        logic       tk;
        logic       se;
        int         idx;
        int         ply;
        int         vol;
        int         tgt;
        int         hex;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input int idx, input int ply,
                             input int vol, input int tgt, input int hex);
        check({name, ".idx"}, int'(idx_a), idx);
        check({name, ".playing"}, int'(ply_a), ply);
        check({name, ".vol_out"}, int'(vol_a), vol);
        check({name, ".vol_tgt"}, int'(tgt_a), tgt);
        check({name, ".hex"}, int'(hex_a), hex);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ps2_byte = b;
        ps2_vld  = 1'b1;
        @(negedge clk);
        ps2_vld  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{KEY_BRK,  1'b1, 1'b0, 1'b0, 0, 0, 0, 8, 1};
        vecs[1]  = '{KEY_NEXT, 1'b1, 1'b0, 1'b0, 0, 0, 0, 8, 1};
        vecs[2]  = '{KEY_NEXT, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8, 2};
        vecs[3]  = '{KEY_PREV, 1'b1, 1'b0, 1'b0, 0, 0, 0, 8, 1};
        vecs[4]  = '{KEY_VUP,  1'b1, 1'b0, 1'b0, 0, 0, 0, 9, 1};
        vecs[5]  = '{KEY_VDN,  1'b1, 1'b0, 1'b0, 0, 0, 0, 8, 1};
        vecs[6]  = '{8'h12,    1'b1, 1'b0, 1'b0, 0, 0, 0, 8, 1};
        vecs[7]  = '{KEY_VUP,  1'b0, 1'b0, 1'b0, 0, 0, 0, 8, 1};
        vecs[8]  = '{KEY_BRK,  1'b1, 1'b0, 1'b0, 0, 0, 0, 8, 1};
        vecs[9]  = '{KEY_VUP,  1'b1, 1'b0, 1'b0, 0, 0, 0, 8, 1};
        vecs[10] = '{KEY_VUP,  1'b1, 1'b0, 1'b1, 0, 0, 0, 9, 1};
        vecs[11] = '{8'h00,    1'b0, 1'b1, 1'b1, 0, 0, 0, 9, 1};
        vecs[12] = '{KEY_VDN,  1'b1, 1'b1, 1'b0, 0, 0, 0, 8, 1};
        vecs[13] = '{KEY_PLAY, 1'b0, 1'b1, 1'b0, 0, 0, 0, 8, 1};

        sys_rst  = 1'b1;
        ps2_byte = 8'h00;
        ps2_vld  = 1'b0;
        tick     = 1'b0;
        song_end = 1'b0;
        idle(2);
        check_all("reset", 0, 0, 0, 8, 1);
        sys_rst = 1'b0;
        idle(1);

        // Decode / break filtering / STOP-state behaviour, one cycle per row.
        for (int i = 0; i < 14; i++) begin
            ps2_byte = vecs[i].b;
            ps2_vld  = vecs[i].vld;
            tick     = vecs[i].tk;
            song_end = vecs[i].se;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].idx, vecs[i].ply,
                      vecs[i].vol, vecs[i].tgt, vecs[i].hex);
        end
        ps2_vld = 1'b0; tick = 1'b0; song_end = 1'b0;

        // Volume target saturation.
        for (int i = 0; i < 10; i++) send(KEY_VUP);
        check("vup_sat", int'(tgt_a), 15);
        for (int i = 0; i < 20; i++) send(KEY_VDN);
        check("vdn_sat", int'(tgt_a), 0);
        for (int i = 0; i < 8; i++) send(KEY_VUP);
        check("vol_back", int'(tgt_a), 8);

        // Park both instances on the last track while stopped.
        for (int i = 0; i < 3; i++) send(KEY_NEXT);
        check_all("stop_next3", 3, 0, 0, 8, 4);
        check("stop_next3.b", int'(idx_b), 3);

        // Play: fade in 0 -> 8 over 16 ticks.
        send(KEY_PLAY);
        check("fi.playing", int'(ply_a), 1);
        check("fi.vol0", int'(vol_a), 0);
        ticks(1);
        check("fi.tick1", int'(vol_a), 0);
        ticks(1);
        check("fi.tick2", int'(vol_a), 1);
        ticks(14);
        check("fi.tick16", int'(vol_a), 8);
        idle(1);

        // Next from the last track: fade out, switch, fade in.
        send(KEY_NEXT);
        ticks(2);
        check("fo.tick2", int'(vol_a), 7);
        check("fo.playing", int'(ply_a), 1);
        ticks(14);
        check("fo.vol0", int'(vol_a), 0);
        idle(2);
        check("sw.idx_wrap", int'(idx_a), 0);
        check("sw.hex_wrap", int'(hex_a), 1);
        check("sw.idx_sat", int'(idx_b), 3);
        check("sw.hex_sat", int'(hex_b), 4);
        check("sw.playing", int'(ply_a), 1);
        ticks(16);
        check("sw.fade_in", int'(vol_a), 8);
        idle(1);

        // Pause, then prev while paused, then resume.
        send(KEY_PLAY);
        ticks(16);
        idle(1);
        check("pause.playing", int'(ply_a), 0);
        check("pause.vol", int'(vol_a), 0);
        send(KEY_PREV);
        check("pause.prev_a", int'(idx_a), 3);
        check("pause.prev_b", int'(idx_b), 2);
        check("pause.still", int'(ply_a), 0);
        send(KEY_PLAY);
        check("resume.playing", int'(ply_a), 1);
        ticks(16);
        idle(1);
        check("resume.vol", int'(vol_a), 8);

        // Next then prev during fade-out: prev wins; then stop mid-fade.
        send(KEY_NEXT);
        ticks(2);
        send(KEY_PREV);
        ticks(14);
        idle(2);
        check("lastwins.a", int'(idx_a), 2);
        check("lastwins.b", int'(idx_b), 1);
        ticks(4);
        check("lastwins.fade", int'(vol_a), 2);
        send(KEY_STOP);
        check("stop.vol", int'(vol_a), 0);
        check("stop.playing", int'(ply_a), 0);
        check("stop.idx", int'(idx_a), 2);

        // song_end handling at track 1.
        send(KEY_PREV);
        check("se.setup", int'(idx_a), 1);
        send(KEY_PLAY);
        ticks(16);
        idle(1);
        @(negedge clk);
        ps2_byte = KEY_VUP; ps2_vld = 1'b1; song_end = 1'b1;
        @(negedge clk);
        ps2_vld = 1'b0; song_end = 1'b0;
        check("se.drop_playing", int'(ply_a), 1);
        check("se.drop_tgt", int'(tgt_a), 9);
        check("se.drop_idx", int'(idx_a), 1);
        send(KEY_VDN);
        @(negedge clk);
        song_end = 1'b1;
        @(negedge clk);
        song_end = 1'b0;
`ifdef PLAYER_AUTO_NEXT_EN
        check("se.auto_playing", int'(ply_a), 1);
        ticks(16);
        idle(2);
        check("se.auto_idx", int'(idx_a), 2);
`else
        check("se.stop_playing", int'(ply_a), 0);
        check("se.stop_vol", int'(vol_a), 0);
        check("se.stop_idx", int'(idx_a), 1);
`endif

        // Asynchronous reset in the middle of a fade-in.
        send(KEY_STOP);
        send(KEY_VUP);
        send(KEY_PLAY);
        ticks(4);
        check("rst.pre_vol", int'(vol_a), 2);
        check("rst.pre_tgt", int'(tgt_a), 9);
        #3 sys_rst = 1'b1;
        #1;
        check_all("rst.async", 0, 0, 0, 8, 1);
        @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        check_all("rst.after", 0, 0, 0, 8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
